forwarding_unit_ex: RTL and testbench

FORWARDING_UNIT_EX -- requirements
Module: forwarding_unit_ex

---
 rtl/forwarding_unit_ex_pkg.sv | 18 +
 rtl/fwd_select.sv | 32 +++
 rtl/forwarding_unit_ex.sv | 79 +++++++
 tb/tb_forwarding_unit_ex.sv | 139 +++++++++++++
 4 files changed

// File: rtl/forwarding_unit_ex_pkg.sv
// Shared opcode constants and datapath widths for the EX-stage forwarding unit.
// Pure declarations; no logic, no latency, no backpressure.
package forwarding_unit_ex_pkg;

    localparam int REG_W  = 5;
    localparam int DATA_W = 32;
    localparam int OP_W   = 6;

    localparam logic [OP_W-1:0] OP_J   = 6'b000010;
    localparam logic [OP_W-1:0] OP_JAL = 6'b000011;
    localparam logic [OP_W-1:0] OP_LW  = 6'b100011;
    localparam logic [OP_W-1:0] OP_SW  = 6'b101011;

    function automatic logic is_jump(input logic [OP_W-1:0] op);
        return (op == OP_J) || (op == OP_JAL);
    endfunction

endpackage

// File: rtl/fwd_select.sv
// Combinational source-operand forwarding select, MEM result preferred over WB.
// Zero latency; no backpressure (pure function of its inputs).
module fwd_select
    import forwarding_unit_ex_pkg::*;
(
    input  logic [REG_W-1:0]  src_i,
    input  logic              en_i,
    input  logic [REG_W-1:0]  mem_rd_i,
    input  logic [REG_W-1:0]  wb_rd_i,
    input  logic [DATA_W-1:0] mem_dat_i,
    input  logic [DATA_W-1:0] wb_dat_i,
    output logic              hit_o,
    output logic [DATA_W-1:0] dat_o
);

    logic src_live;
    assign src_live = en_i && (src_i != '0);

    // MEM holds the youngest producer, so it is checked first.
    always_comb begin
        hit_o = 1'b0;
        dat_o = '0;
        if (src_live && (src_i == mem_rd_i)) begin
            hit_o = 1'b1;
            dat_o = mem_dat_i;
        end else if (src_live && (src_i == wb_rd_i)) begin
            hit_o = 1'b1;
            dat_o = wb_dat_i;
        end
    end

endmodule

// File: rtl/forwarding_unit_ex.sv
// EX-stage forwarding unit: picks MEM/WB results for operands A and B, registered.
// One-cycle latency; no backpressure, a new instruction is accepted every cycle.
module forwarding_unit_ex
    import forwarding_unit_ex_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic [OP_W-1:0]   opcode,
    input  logic [REG_W-1:0]  EX_RS,
    input  logic [REG_W-1:0]  EX_RT,
    input  logic [REG_W-1:0]  MEM_RD,
    input  logic [REG_W-1:0]  WB_RD,
    input  logic [DATA_W-1:0] MEM_RD_DATA_I,
    input  logic [DATA_W-1:0] WB_RD_DATA_I,
    input  logic              ALUSrc,
    output logic [DATA_W-1:0] MEM_RD_DATA_O,
    output logic [DATA_W-1:0] WB_RD_DATA_O,
    output logic              FW_sig1,
    output logic              FW_sig2
);

    logic              en_a;
    logic              en_b;
    logic              hit_a_d;
    logic              hit_b_d;
    logic [DATA_W-1:0] dat_a_d;
    logic [DATA_W-1:0] dat_b_d;

    logic              hit_a_q;
    logic              hit_b_q;
    logic [DATA_W-1:0] dat_a_q;
    logic [DATA_W-1:0] dat_b_q;

    // Jumps read no registers; an immediate replaces operand B entirely.
    assign en_a = !is_jump(opcode);
    assign en_b = !is_jump(opcode) && !ALUSrc;

    fwd_select u_sel_a (
        .src_i     (EX_RS),
        .en_i      (en_a),
        .mem_rd_i  (MEM_RD),
        .wb_rd_i   (WB_RD),
        .mem_dat_i (MEM_RD_DATA_I),
        .wb_dat_i  (WB_RD_DATA_I),
        .hit_o     (hit_a_d),
        .dat_o     (dat_a_d)
    );

    fwd_select u_sel_b (
        .src_i     (EX_RT),
        .en_i      (en_b),
        .mem_rd_i  (MEM_RD),
        .wb_rd_i   (WB_RD),
        .mem_dat_i (MEM_RD_DATA_I),
        .wb_dat_i  (WB_RD_DATA_I),
        .hit_o     (hit_b_d),
        .dat_o     (dat_b_d)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            hit_a_q <= 1'b0;
            hit_b_q <= 1'b0;
            dat_a_q <= '0;
            dat_b_q <= '0;
        end else begin
            hit_a_q <= hit_a_d;
            hit_b_q <= hit_b_d;
            dat_a_q <= dat_a_d;
            dat_b_q <= dat_b_d;
        end
    end

    assign FW_sig1       = hit_a_q;
    assign FW_sig2       = hit_b_q;
    assign MEM_RD_DATA_O = dat_a_q;
    assign WB_RD_DATA_O  = dat_b_q;

endmodule

// File: tb/tb_forwarding_unit_ex.sv
// Directed and random stimulus for forwarding_unit_ex, checked against a rule-level model
// every cycle plus literal expectations for the hand-worked vectors.
module tb_forwarding_unit_ex;

    logic        clk = 1'b0;
    logic        rst;
    logic [5:0]  opcode;
    logic [4:0]  EX_RS, EX_RT, MEM_RD, WB_RD;
    logic [31:0] MEM_RD_DATA_I, WB_RD_DATA_I;
    logic        ALUSrc;
    logic [31:0] MEM_RD_DATA_O, WB_RD_DATA_O;
    logic        FW_sig1, FW_sig2;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    forwarding_unit_ex dut (
        .clk           (clk),
        .rst           (rst),
        .opcode        (opcode),
        .EX_RS         (EX_RS),
        .EX_RT         (EX_RT),
        .MEM_RD        (MEM_RD),
        .WB_RD         (WB_RD),
        .MEM_RD_DATA_I (MEM_RD_DATA_I),
        .WB_RD_DATA_I  (WB_RD_DATA_I),
        .ALUSrc        (ALUSrc),
        .MEM_RD_DATA_O (MEM_RD_DATA_O),
        .WB_RD_DATA_O  (WB_RD_DATA_O),
        .FW_sig1       (FW_sig1),
        .FW_sig2       (FW_sig2)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Model: what operand forwarding must produce for one source register.
    function automatic logic [32:0] model_operand(input logic used, input logic [4:0] src,
                                                  input logic [4:0] mrd, input logic [4:0] wrd,
                                                  input logic [31:0] md, input logic [31:0] wd);
        if (!used || src == 5'd0) return 33'd0;
        if (src == mrd)           return {1'b1, md};
        if (src == wrd)           return {1'b1, wd};
        return 33'd0;
    endfunction

    logic        have_exp = 1'b0;
    logic [32:0] exp_a, exp_b;

    always @(posedge clk) begin
        logic jump;
        jump = (opcode == 6'd2) || (opcode == 6'd3);
        if (rst) begin
            exp_a = 33'd0;
            exp_b = 33'd0;
        end else begin
            exp_a = model_operand(!jump, EX_RS, MEM_RD, WB_RD, MEM_RD_DATA_I, WB_RD_DATA_I);
            exp_b = model_operand(!jump && !ALUSrc, EX_RT, MEM_RD, WB_RD, MEM_RD_DATA_I, WB_RD_DATA_I);
        end
        have_exp = 1'b1;
    end

    always @(negedge clk) begin
        if (have_exp) begin
            chk("model_FW_sig1", {31'd0, FW_sig1}, {31'd0, exp_a[32]});
            chk("model_MEM_RD_DATA_O", MEM_RD_DATA_O, exp_a[31:0]);
            chk("model_FW_sig2", {31'd0, FW_sig2}, {31'd0, exp_b[32]});
            chk("model_WB_RD_DATA_O", WB_RD_DATA_O, exp_b[31:0]);
        end
    end

    task automatic drive(input logic r, input logic [5:0] op, input logic [4:0] rs, input logic [4:0] rt,
                         input logic [4:0] mrd, input logic [4:0] wrd,
                         input logic [31:0] md, input logic [31:0] wd, input logic als);
        @(negedge clk);
        rst = r; opcode = op; EX_RS = rs; EX_RT = rt; MEM_RD = mrd; WB_RD = wrd;
        MEM_RD_DATA_I = md; WB_RD_DATA_I = wd; ALUSrc = als;
    endtask

    task automatic vec(input string name, input logic r, input logic [5:0] op,
                       input logic [4:0] rs, input logic [4:0] rt,
                       input logic [4:0] mrd, input logic [4:0] wrd,
                       input logic [31:0] md, input logic [31:0] wd, input logic als,
                       input logic e1, input logic [31:0] ed1, input logic e2, input logic [31:0] ed2);
        drive(r, op, rs, rt, mrd, wrd, md, wd, als);
        @(posedge clk);
        #1;
        chk({name, "_FW_sig1"}, {31'd0, FW_sig1}, {31'd0, e1});
        chk({name, "_MEM_RD_DATA_O"}, MEM_RD_DATA_O, ed1);
        chk({name, "_FW_sig2"}, {31'd0, FW_sig2}, {31'd0, e2});
        chk({name, "_WB_RD_DATA_O"}, WB_RD_DATA_O, ed2);
    endtask

    initial begin
        rst = 1'b1; opcode = 6'd0; EX_RS = 5'd0; EX_RT = 5'd0; MEM_RD = 5'd0; WB_RD = 5'd0;
        MEM_RD_DATA_I = 32'd0; WB_RD_DATA_I = 32'd0; ALUSrc = 1'b0;

        // reset with a match on both operands present
        vec("reset", 1'b1, 6'b100011, 5'd2, 5'd3, 5'd2, 5'd3, 32'hA, 32'h5, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
        vec("lw_mem_a", 1'b0, 6'b100011, 5'd2, 5'd3, 5'd2, 5'd4, 32'hA, 32'h5, 1'b0, 1'b1, 32'hA, 1'b0, 32'h0);
        vec("lw_wb_a", 1'b0, 6'b100011, 5'd2, 5'd3, 5'd4, 5'd2, 32'hA, 32'h5, 1'b0, 1'b1, 32'h5, 1'b0, 32'h0);
        vec("mem_prio_a", 1'b0, 6'b100011, 5'd2, 5'd3, 5'd2, 5'd2, 32'hA, 32'h5, 1'b1, 1'b1, 32'hA, 1'b0, 32'h0);
        vec("no_match", 1'b0, 6'b100011, 5'd2, 5'd3, 5'd4, 5'd4, 32'hA, 32'h5, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
        vec("rtype_wb_b", 1'b0, 6'b000000, 5'd2, 5'd3, 5'd4, 5'd3, 32'hA, 32'h5, 1'b0, 1'b0, 32'h0, 1'b1, 32'h5);
        vec("reg0", 1'b0, 6'b000000, 5'd0, 5'd0, 5'd0, 5'd0, 32'hA, 32'h5, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
        vec("j", 1'b0, 6'b000010, 5'd2, 5'd3, 5'd2, 5'd3, 32'hA, 32'h5, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
        vec("jal", 1'b0, 6'b000011, 5'd2, 5'd3, 5'd2, 5'd3, 32'hA, 32'h5, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
        vec("same_src", 1'b0, 6'b000000, 5'd7, 5'd7, 5'd7, 5'd1, 32'hDEADBEEF, 32'h5, 1'b0, 1'b1, 32'hDEADBEEF, 1'b1, 32'hDEADBEEF);
        vec("sw_mem_prio_b", 1'b0, 6'b101011, 5'd1, 5'd5, 5'd5, 5'd5, 32'hFFFFFFFF, 32'h12345678, 1'b0, 1'b0, 32'h0, 1'b1, 32'hFFFFFFFF);
        vec("alusrc_kill_b", 1'b0, 6'b001000, 5'd6, 5'd5, 5'd5, 5'd6, 32'h80000001, 32'h7FFFFFFE, 1'b1, 1'b1, 32'h7FFFFFFE, 1'b0, 32'h0);
        vec("beq_both", 1'b0, 6'b000100, 5'd31, 5'd30, 5'd30, 5'd31, 32'h0BADF00D, 32'hCAFEF00D, 1'b0, 1'b1, 32'hCAFEF00D, 1'b1, 32'h0BADF00D);
        vec("rst_pending", 1'b1, 6'b000000, 5'd7, 5'd7, 5'd7, 5'd7, 32'h11111111, 32'h22222222, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
        vec("first_after_rst", 1'b0, 6'b000000, 5'd7, 5'd7, 5'd7, 5'd7, 32'h11111111, 32'h22222222, 1'b0, 1'b1, 32'h11111111, 1'b1, 32'h11111111);

        for (int i = 0; i < 300; i++) begin
            logic [5:0] ops [6];
            ops[0] = 6'b000000; ops[1] = 6'b100011; ops[2] = 6'b101011;
            ops[3] = 6'b000010; ops[4] = 6'b000011; ops[5] = 6'b000100;
            drive(($urandom_range(0, 19) == 0), ops[$urandom_range(0, 5)],
                  5'($urandom_range(0, 5)), 5'($urandom_range(0, 5)),
                  5'($urandom_range(0, 5)), 5'($urandom_range(0, 5)),
                  $urandom, $urandom, 1'($urandom_range(0, 1)));
        end

        @(negedge clk);
        @(negedge clk);
        #1;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
